// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU with a registered response slot.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention instead of round-robin.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [7:0]  req_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic        last_grant_r;
  logic        grant_id_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic [3:0]  op_sel_r;
  logic        grant_s;
  logic        accept_s;

  assign alu_a   = op_a_r;
  assign alu_b   = op_b_r;
  assign alu_sel = op_sel_r;

  // Pick the requester to serve among the currently valid ones.
  always_comb begin
    grant_s = 1'b0;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_s = 1'b0;
`else
      grant_s = ~last_grant_r;
`endif
    end else if (req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // A new operation can enter when the response slot is empty or is draining this cycle.
  always_comb begin
    accept_s = 1'b0;
    if (reset) begin
      accept_s = 1'b0;
    end else if ((state_r == IDLE) || ((state_r == RESP) && rsp_ready)) begin
      accept_s = |req_valid;
    end else begin
      accept_s = 1'b0;
    end
  end

  // One-hot handshake back to the granted requester in the accept cycle.
  always_comb begin
    req_ready = 2'b00;
    if (accept_s) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Control FSM with operand, grant and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      grant_id_r   <= 1'b0;
      op_a_r       <= 32'd0;
      op_b_r       <= 32'd0;
      op_sel_r     <= 4'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 32'd0;
      rsp_flags    <= 3'd0;
    end else begin
      if (accept_s) begin
        last_grant_r <= grant_s;
        grant_id_r   <= grant_s;
        op_a_r       <= grant_s ? req_a[63:32] : req_a[31:0];
        op_b_r       <= grant_s ? req_b[63:32] : req_b[31:0];
        op_sel_r     <= grant_s ? req_sel[7:4] : req_sel[3:0];
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_id     <= grant_id_r;
          rsp_valid  <= 1'b1;
          state_r    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= accept_s ? EXEC : IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
